// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for the 4-PE core.
// Sums NUM_TILES psum beats per lane, then requantizes to int8.
module psum_accumulator #(
  parameter int NUM_TILES = 4,
  parameter int SHIFT     = 4,
  parameter int RELU_EN   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             psum_valid_i,
  input  logic [3:0][19:0] psum_in_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [3:0][7:0]  out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       tile_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUTPUT
  } state_e;

  localparam logic [3:0] LAST = 4'(NUM_TILES - 1);
  localparam logic signed [24:0] RND = 25'(1) << (SHIFT - 1);

  state_e            state_q, state_d;
  logic signed [23:0] acc_q [4];
  logic signed [23:0] acc_d [4];
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  // Round-half-up, arithmetic shift, optional ReLU, int8 saturation.
  function automatic logic [7:0] requant(input logic signed [23:0] a);
    logic signed [24:0] s;
    logic signed [24:0] r;
    s = $signed({a[23], a}) + RND;
    r = s >>> SHIFT;
    if (RELU_EN != 0 && r < 0) r = '0;
    if (r > 25'sd127) return 8'h7f;
    if (r < -25'sd128) return 8'h80;
    return r[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i];
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int i = 0; i < 4; i++) acc_d[i] = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (psum_valid_i) begin
          for (int i = 0; i < 4; i++)
            acc_d[i] = acc_q[i] +
              {{4{psum_in_i[i][19]}}, psum_in_i[i]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    out_valid_o = (state_q == S_OUTPUT);
    busy_o      = (state_q != S_IDLE);
    done_o      = done_q;
    tile_cnt_o  = cnt_q;
    for (int i = 0; i < 4; i++)
      out_data_o[i] = out_valid_o ? requant(acc_q[i]) : 8'h00;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter NUM_TILES, default 4, psum beats per output vector; legal range 1..16.
REQ-002 Parameter SHIFT, default 4, requantization right-shift amount; legal range 1..15.
REQ-003 Parameter RELU_EN, default 1, clamps negative results to zero when 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a new accumulation.
REQ-007 psum_valid  input  1  qualifies psum_in; high when the 4-PE core output is valid.
REQ-008 psum_in[0:3]  input  4x20 signed  per-row partial sums from the 4-PE core.
REQ-009 out_ready  input  1  downstream ready.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_data[0:3]  output  4x8 signed  requantized row results.
REQ-012 busy  output  1  high in ACCUM and OUTPUT.
REQ-013 done  output  1  one-cycle pulse after the output handshake.
REQ-014 tile_cnt  output  4  psum beats accepted in the current accumulation.

Function
REQ-015 States: IDLE, ACCUM, OUTPUT; the block SHALL occupy exactly one state per cycle.
REQ-016 IDLE + start: clear acc[0:3] and tile_cnt to 0; next state ACCUM; psum_valid in the same cycle is ignored.
REQ-017 ACCUM + psum_valid: acc[i] <= acc[i] + sign_extend(psum_in[i]) into 24-bit signed; tile_cnt increments.
REQ-018 ACCUM + psum_valid low: acc and tile_cnt hold; gaps of any length are legal.
REQ-019 ACCUM: the beat with tile_cnt == NUM_TILES-1 moves to OUTPUT; out_valid is high the cycle after that beat (latency 1).
REQ-020 Requantization per lane, from the acc registers: r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic); if RELU_EN and r<0 then r=0; saturate r to [-128, 127].
REQ-021 OUTPUT: out_valid=1; out_data holds stable until out_valid && out_ready.
REQ-022 OUTPUT handshake: next state IDLE, done=1 for exactly the next cycle, out_valid=0 that cycle.
REQ-023 start during ACCUM or OUTPUT is ignored; psum_valid during IDLE or OUTPUT is ignored and SHALL NOT modify acc.
REQ-024 out_data SHALL read 0 whenever out_valid=0.
REQ-025 The 24-bit accumulator SHALL NOT overflow for NUM_TILES<=16; no accumulator saturation logic is required.
REQ-026 done SHALL NOT assert together with out_valid.

Reset
REQ-027 rst=1 at a clock edge: state IDLE; acc, tile_cnt, out_valid, done, busy, out_data all 0, overriding every other input.
REQ-028 rst mid-ACCUM or mid-OUTPUT aborts the operation; the pending result SHALL NOT be output and no done pulse is produced.

Verification
REQ-029 Reset: hold rst 2 cycles with start=1, psum_valid=1 -> busy=0, out_valid=0, done=0, tile_cnt=0, out_data all 0.
REQ-030 Basic (defaults): start, then lane0 psums 16,32,48,64 back-to-back -> acc0=160, out_valid the cycle after the 4th beat, out_data[0]=10.
REQ-031 Gaps and backpressure: 2-cycle psum_valid gaps between beats, out_ready low 3 cycles -> tile_cnt holds in gaps, out_data stable while stalled, done one cycle after handshake.
REQ-032 Saturation/ReLU: lane1 4x10000 -> 127; lane2 4x(-5000) -> 0 with RELU_EN=1, -128 with RELU_EN=0.
REQ-033 Rounding (RELU_EN=0): acc=24 -> 2; acc=23 -> 1; acc=-24 -> -1; acc=-25 -> -2.
REQ-034 Reset mid-op: rst after 2 beats, then start + 4 beats of 16 -> out_data[0]=4, no stale contribution, exactly one done.
